// File: rtl/parity_generator_pkg.sv
// Shared types for the nibble+parity link: the {data, parity_bit} frame and
// the parity helper used by both the generator and checker sides.
package parity_generator_pkg;

    typedef struct packed {
        logic [3:0] data;
        logic       parity_bit;
    } data_t;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic calc_parity(input logic [3:0] data, input bit odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_generator_if.sv
// Valid/ready bus for the parity generator: nibbles in, parity frames out.
// The slave modport is the generator's view; the master modport drives it.
interface parity_generator_if;

    logic [3:0]                  in_data;
    logic                        in_valid;
    logic                        in_ready;
    parity_generator_pkg::data_t data_out;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output data_out,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  data_out,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/parity_generator_skid_buf.sv
// parity_skid_buf: 2-entry FIFO of frames with registered outputs. The head
// register drives the consumer directly; the tail absorbs one stall cycle.
module parity_skid_buf
    import parity_generator_pkg::*;
(
    input  logic  clk,
    input  logic  rstN,
    input  data_t i_pushData,
    input  logic  i_pushValid,
    output logic  o_pushReady,
    output data_t o_popData,
    output logic  o_popValid,
    input  logic  i_popReady
);

    data_t r_head;
    data_t r_tail;
    logic  r_headValid;
    logic  r_tailValid;
    logic  w_push;
    logic  w_pop;

    // The tail only fills once the head is occupied, so a free tail means
    // occupancy < 2; ready therefore depends on registered state alone.
    assign o_pushReady = !r_tailValid;
    assign w_push      = i_pushValid && !r_tailValid;
    assign w_pop       = r_headValid && i_popReady;
    assign o_popData   = r_head;
    assign o_popValid  = r_headValid;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_headValid <= 1'b0;
            r_tailValid <= 1'b0;
        end else if (w_pop) begin
            if (r_tailValid) begin
                r_head      <= r_tail;
                r_tailValid <= 1'b0;
            end else if (w_push) begin
                r_head <= i_pushData;
            end else begin
                r_headValid <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_headValid) begin
                r_head      <= i_pushData;
                r_headValid <= 1'b1;
            end else begin
                r_tail      <= i_pushData;
                r_tailValid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_generator.sv
// Transmit side of the nibble+parity link: parity at push, 2-entry buffer,
// frames-sent counter. Optional macro PARITY_ERR_INJECT_EN adds inject_err.
module parity_generator
    import parity_generator_pkg::*;
#(
    parameter bit ODD_PARITY  = 1'b0,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
`ifdef PARITY_ERR_INJECT_EN
    input  logic                   inject_err,
`endif
    parity_generator_if.slave      bus,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    data_t                  w_frame;
    logic                   w_inject;
    logic                   w_pop;
    logic [FRAME_CNT_W-1:0] r_frameCnt;

`ifdef PARITY_ERR_INJECT_EN
    assign w_inject = inject_err;
`else
    assign w_inject = 1'b0;
`endif

    always_comb begin
        w_frame            = '0;
        w_frame.data       = bus.in_data;
        w_frame.parity_bit = calc_parity(bus.in_data, ODD_PARITY) ^ w_inject;
    end

    parity_skid_buf u_buf (
        .clk         (clk),
        .rstN        (rstN),
        .i_pushData  (w_frame),
        .i_pushValid (bus.in_valid),
        .o_pushReady (bus.in_ready),
        .o_popData   (bus.data_out),
        .o_popValid  (bus.out_valid),
        .i_popReady  (bus.out_ready)
    );

    assign w_pop     = bus.out_valid && bus.out_ready;
    assign frame_cnt = r_frameCnt;

    // Free-running count of handed-off frames; wraps silently.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_frameCnt <= '0;
        end else if (w_pop) begin
            r_frameCnt <= r_frameCnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_parity_generator.sv
// Self-checking bench for parity_generator: two instances (even/8-bit counter
// and odd/4-bit counter) share stimulus and are compared against a queue model.
module tb_parity_generator;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       inValid = 1'b0;
    logic [3:0] inData = 4'h0;
    logic       outReady = 1'b0;
    logic       inject = 1'b0;
    logic [7:0] frameCnt0;
    logic [3:0] frameCnt1;

    int checks = 0;
    int failures = 0;

    // Model: each entry is {data, injected}; frameCount is the total of pops.
    logic [4:0] modelQ[$];
    int         frameCount = 0;

    always #5 clk = ~clk;

    parity_generator_if bus0 ();
    parity_generator_if bus1 ();

    assign bus0.in_data   = inData;
    assign bus0.in_valid  = inValid;
    assign bus0.out_ready = outReady;
    assign bus1.in_data   = inData;
    assign bus1.in_valid  = inValid;
    assign bus1.out_ready = outReady;

    parity_generator #(.ODD_PARITY(1'b0), .FRAME_CNT_W(8)) dut0 (
        .clk        (clk),
        .rstN       (rstN),
`ifdef PARITY_ERR_INJECT_EN
        .inject_err (inject),
`endif
        .bus        (bus0.slave),
        .frame_cnt  (frameCnt0)
    );

    parity_generator #(.ODD_PARITY(1'b1), .FRAME_CNT_W(4)) dut1 (
        .clk        (clk),
        .rstN       (rstN),
`ifdef PARITY_ERR_INJECT_EN
        .inject_err (inject),
`endif
        .bus        (bus1.slave),
        .frame_cnt  (frameCnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] expFrame(input logic [4:0] entry, input bit odd);
        logic [3:0] d;
        logic       p;
        d = entry[4:1];
        p = (($countones(d) % 2) == 1) ^ odd ^ entry[0];
        return {d, p};
    endfunction

    task automatic compareModel();
        checkOutput("out_valid0", 32'(bus0.out_valid), 32'(modelQ.size() > 0));
        checkOutput("out_valid1", 32'(bus1.out_valid), 32'(modelQ.size() > 0));
        checkOutput("in_ready0", 32'(bus0.in_ready), 32'(modelQ.size() < 2));
        checkOutput("in_ready1", 32'(bus1.in_ready), 32'(modelQ.size() < 2));
        checkOutput("frame_cnt0", 32'(frameCnt0), 32'(frameCount % 256));
        checkOutput("frame_cnt1", 32'(frameCnt1), 32'(frameCount % 16));
        if (modelQ.size() > 0) begin
            checkOutput("data_out0", 32'(bus0.data_out), 32'(expFrame(modelQ[0], 1'b0)));
            checkOutput("data_out1", 32'(bus1.data_out), 32'(expFrame(modelQ[0], 1'b1)));
        end
    endtask

    // Drive one cycle of inputs, advance the model to the post-edge state,
    // then compare on the following falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r, input logic inj);
        logic doPush;
        logic doPop;
        logic injEff;
        inValid  = v;
        inData   = d;
        outReady = r;
        inject   = inj;
`ifdef PARITY_ERR_INJECT_EN
        injEff = inj;
`else
        injEff = 1'b0;
`endif
        doPop  = (modelQ.size() > 0) && r;
        doPush = v && (modelQ.size() < 2);
        if (doPop) begin
            void'(modelQ.pop_front());
            frameCount++;
        end
        if (doPush) modelQ.push_back({d, injEff});
        @(negedge clk);
        compareModel();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic doReset();
        #2;
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        inject   = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("rst_frame_cnt", 32'(frameCnt0), 32'd0);
        checkOutput("rst_data_out", 32'(bus0.data_out), 32'd0);
        checkOutput("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
        checkOutput("rst_frame_cnt1", 32'(frameCnt1), 32'd0);
        modelQ.delete();
        frameCount = 0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        doReset();

        // Even/odd parity on single frames.
        applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0);
        checkOutput("even_1011", 32'(bus0.data_out), 32'b10111);
        checkOutput("odd_1011", 32'(bus1.data_out), 32'b10110);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        checkOutput("even_0000", 32'(bus0.data_out), 32'b00000);
        checkOutput("odd_0000", 32'(bus1.data_out), 32'b00001);
        applyStimulus(1'b0, 4'hA, 1'b1, 1'b0);

        // Backpressure: two accepted, third held until the consumer resumes.
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 32'(bus0.in_ready), 32'd0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        checkOutput("bp_head", 32'(bus0.data_out.data), 32'h1);
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
        checkOutput("bp_second", 32'(bus0.data_out.data), 32'h2);
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
        checkOutput("bp_third", 32'(bus0.data_out.data), 32'h3);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

        // Reset with frames in flight discards them.
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        doReset();

        // Streaming 0..F with no bubbles, then counter wrap on the 4-bit instance.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("stream_cnt16", 32'(frameCnt0), 32'd16);
        checkOutput("stream_cnt4_wrap", 32'(frameCnt1), 32'd0);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("wrap_17", 32'(frameCnt1), 32'd1);
        checkOutput("cnt_17", 32'(frameCnt0), 32'd17);

`ifdef PARITY_ERR_INJECT_EN
        doReset();
        applyStimulus(1'b1, 4'h4, 1'b1, 1'b0);
        checkOutput("inj_before", 32'(bus0.data_out), 32'b01001);
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b1);
        checkOutput("inj_frame", 32'(bus0.data_out), 32'b01011);
        applyStimulus(1'b1, 4'h6, 1'b1, 1'b0);
        checkOutput("inj_after", 32'(bus0.data_out), 32'b01100);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 4'($urandom),
                              $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
